mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer end of the EX/MEM pipeline register: executes the MEM stage of the pipelined CPU.
//  Resolves branch/jump (drives MEM_PCSrc/MEM_NextPC back to fetch and to the EX/MEM flush).
//  Runs load/store to data memory over a req/ack handshake with wait states, stalling the pipe.
//  Hosts the MEM/WB register that feeds write-back.
// PARAMETERS
//  MAX_WAIT  15  max cycles in WAIT before a memory timeout is declared (1..255)
// PORTS
//  Clk           in   1   clock; all state updates on falling edge, as for the pipeline registers
//  Clrn          in   1   asynchronous active-low reset
//  MEM_Btarg     in   32  branch target
//  MEM_Jtarg     in   32  jump target
//  MEM_busB      in   32  store data
//  MEM_ALUout    in   32  ALU result / memory address
//  MEM_Rw        in   5   destination register
//  MEM_Zero      in   1   ALU zero flag
//  MEM_Overflow  in   1   ALU overflow flag
//  MEM_RegWr, MEM_MemtoReg, MEM_MemWr, MEM_Branch, MEM_Jump  in  1 each  stage controls
//  MEM_PCSrc     out  1   branch/jump taken
//  MEM_NextPC    out  32  redirect target
//  Stall         out  1   freeze IF..EX/MEM this cycle
//  dm_req        out  1   memory request
//  dm_we         out  1   1 = store
//  dm_addr       out  32  word address (= MEM_ALUout)
//  dm_wdata      out  32  store data
//  dm_ack        in   1   memory accepted/completed
//  dm_rdata      in   32  load data, valid with dm_ack
//  WB_Dout       out  32  load data to WB
//  WB_ALUout     out  32  ALU result to WB
//  WB_Rw         out  5   destination register to WB
//  WB_RegWr      out  1   write-back enable
//  WB_MemtoReg   out  1   select WB_Dout
//  MemErr        out  1   sticky error flag (timeout/misaligned)
// BEHAVIOUR
//  - Branch/jump resolution (combinational):
//    - MEM_PCSrc = (MEM_Branch & MEM_Zero) | MEM_Jump.
//    - MEM_NextPC = MEM_Jump ? MEM_Jtarg : MEM_Btarg.
//  - Memory operation gating:
//    - memop = (MEM_MemWr | MEM_MemtoReg) & ~MEM_Overflow & (MEM_ALUout[1:0]==0).
//    - Misaligned address (memop candidate with ALUout[1:0]!=0): no request is issued, MemErr is set, and RegWr is dropped.
//    - On overflow, no memory op is issued and WB_RegWr is written 0.
//  - FSM states and transitions:
//    - IDLE:
//      - dm_req = memop (combinational); dm_we = MEM_MemWr; dm_addr = MEM_ALUout; dm_wdata = MEM_busB.
//      - memop & dm_ack: op completes this cycle with no stall.
//      - memop & ~dm_ack: Stall = 1; next state is WAIT; wait counter is cleared.
//    - WAIT:
//      - dm_req stays high with stable addr/we/wdata; Stall = ~dm_ack.
//      - dm_ack: complete and return to IDLE.
//      - Otherwise the counter increments; counter reaching MAX_WAIT goes to ERR.
//    - ERR (one cycle):
//      - dm_req = 0; MemErr <= 1 (sticky until reset); the op is dropped with WB_RegWr <= 0.
//      - Stall = 0; next state is IDLE.
//  - Load data capture: on a load completion, WB_Dout <= dm_rdata in the same falling edge.
//  - MEM/WB register (falling edge):
//    - Stall = 1: bubble (WB_RegWr <= 0, WB_MemtoReg <= 0); data fields hold.
//    - Otherwise: WB_ALUout <= MEM_ALUout; WB_Rw <= MEM_Rw; WB_MemtoReg <= MEM_MemtoReg.
//    - Otherwise: WB_RegWr <= MEM_RegWr & ~MEM_Overflow & ~(error this cycle).
//  - Latency: 0 stall cycles with a same-cycle ack; N stall cycles for an ack after N cycles; maximum MAX_WAIT+1 cycles.
//  - dm_ack is ignored when no request is outstanding.
//  - A branch and a memory op never coexist in one instruction; MEM_PCSrc is not gated by Stall.
//  - Reset (Clrn = 0, asynchronous, including mid-WAIT):
//    - State IDLE; counter 0; MemErr 0.
//    - All WB_* outputs 0; dm_req forced 0 immediately.
// TESTING
//  - Reset: Clrn=0 mid-WAIT -> dm_req=0 at once; after release WB_*=0, MemErr=0, state IDLE.
//  - Load with ack: MemtoReg=1, ALUout=0x100, dm_ack same cycle, rdata=0xDEADBEEF -> Stall never 1; WB_Dout=0xDEADBEEF, WB_RegWr=1.
//  - Store with wait states: MemWr=1, ack after 3 cycles -> Stall high 3 cycles; dm_addr/wdata stable; WB bubble x3 then WB_RegWr=0.
//  - Timeout: MAX_WAIT=4, no ack -> MemErr=1 after 5 cycles, Stall drops, WB_RegWr=0.
//  - Misaligned/overflow: ALUout=0x102 load -> no dm_req, MemErr=1; Overflow=1 with RegWr=1 -> WB_RegWr=0.
//  - Branch: Branch=1, Zero=1, Btarg=0x40 -> PCSrc=1, NextPC=0x40; Jump=1, Jtarg=0x80 -> NextPC=0x80; Zero=0 -> PCSrc=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the pipelined CPU: branch/jump resolution, data-memory req/ack sequencing, MEM/WB register.
// Latency: redirect and dm_req are combinational; MEM/WB updates on the falling edge; a memory op costs N stall cycles for an ack after N cycles (max MAX_WAIT+1).
// Backpressure: Stall freezes IF..EX/MEM while a request waits for dm_ack; a timeout drops the op through a one-cycle ERR state.
//
// Ports:
//   Clk, Clrn                      falling-edge clock, async active-low reset
//   MEM_*                          EX/MEM register contents (targets, store data, ALU result, controls, flags)
//   MEM_PCSrc, MEM_NextPC          redirect to fetch / EX/MEM flush
//   Stall                          pipeline freeze
//   dm_req/we/addr/wdata/ack/rdata data-memory handshake
//   WB_*                           MEM/WB register outputs
//   MemErr                         sticky timeout / misalignment flag
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [31:0] MEM_Btarg,
    input  logic [31:0] MEM_Jtarg,
    input  logic [31:0] MEM_busB,
    input  logic [31:0] MEM_ALUout,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_Zero,
    input  logic        MEM_Overflow,
    input  logic        MEM_RegWr,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWr,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    output logic        MEM_PCSrc,
    output logic [31:0] MEM_NextPC,
    output logic        Stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] WB_Dout,
    output logic [31:0] WB_ALUout,
    output logic [4:0]  WB_Rw,
    output logic        WB_RegWr,
    output logic        WB_MemtoReg,
    output logic        MemErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Request fields frozen on entry to WAIT so the memory sees a stable
    // request even if the upstream register were to glitch.
    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;

    logic [31:0] wb_dout_q;
    logic [31:0] wb_alu_q;
    logic [4:0]  wb_rw_q;
    logic        wb_regwr_q;
    logic        wb_memtoreg_q;
    logic        mem_err_q;

    logic        mem_cand;
    logic        aligned;
    logic        memop;
    logic        misaligned;
    logic        stall_c;
    logic        req_c;
    logic        complete_c;
    logic        err_c;
    logic        we_eff;

    assign mem_cand   = MEM_MemWr | MEM_MemtoReg;
    assign aligned    = (MEM_ALUout[1:0] == 2'b00);
    assign memop      = mem_cand & ~MEM_Overflow & aligned;
    assign misaligned = mem_cand & ~MEM_Overflow & ~aligned;

    // Branch/jump resolution; never gated by Stall since a branch and a
    // memory op cannot share an instruction.
    assign MEM_PCSrc  = (MEM_Branch & MEM_Zero) | MEM_Jump;
    assign MEM_NextPC = MEM_Jump ? MEM_Jtarg : MEM_Btarg;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        req_c      = 1'b0;
        complete_c = 1'b0;
        err_c      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_c = memop;
                err_c = misaligned;
                if (memop) begin
                    if (dm_ack) begin
                        complete_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (dm_ack) begin
                    complete_c = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_d == MAX_WAIT_C) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                // Stall released here so the timed-out op leaves as a bubble.
                err_c   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign we_eff   = (state_q == S_WAIT) ? req_we_q    : MEM_MemWr;
    assign dm_we    = we_eff;
    assign dm_addr  = (state_q == S_WAIT) ? req_addr_q  : MEM_ALUout;
    assign dm_wdata = (state_q == S_WAIT) ? req_wdata_q : MEM_busB;
    // Reset kills the request combinationally, even mid-WAIT.
    assign dm_req   = req_c & Clrn;
    assign Stall    = stall_c;

    always_ff @(negedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            req_we_q      <= 1'b0;
            req_addr_q    <= 32'd0;
            req_wdata_q   <= 32'd0;
            wb_dout_q     <= 32'd0;
            wb_alu_q      <= 32'd0;
            wb_rw_q       <= 5'd0;
            wb_regwr_q    <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE) begin
                req_we_q    <= MEM_MemWr;
                req_addr_q  <= MEM_ALUout;
                req_wdata_q <= MEM_busB;
            end
            if (err_c) begin
                mem_err_q <= 1'b1;
            end
            if (complete_c && !we_eff) begin
                wb_dout_q <= dm_rdata;
            end
            if (stall_c) begin
                wb_regwr_q    <= 1'b0;
                wb_memtoreg_q <= 1'b0;
            end else begin
                wb_alu_q      <= MEM_ALUout;
                wb_rw_q       <= MEM_Rw;
                wb_memtoreg_q <= MEM_MemtoReg;
                wb_regwr_q    <= MEM_RegWr & ~MEM_Overflow & ~err_c;
            end
        end
    end

    assign WB_Dout     = wb_dout_q;
    assign WB_ALUout   = wb_alu_q;
    assign WB_Rw       = wb_rw_q;
    assign WB_RegWr    = wb_regwr_q;
    assign WB_MemtoReg = wb_memtoreg_q;
    assign MemErr      = mem_err_q;

endmodule
